// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Holds the funct3 access-size codes, the LSU FSM state encoding, the
// default bus-timeout depth, the bus request payload and size decode helpers.
package riscv_mem_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Bus request payload captured when an access is issued.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  // Access size from funct3[1:0]; reserved encodings fall through to word.
  function automatic acc_size_e size_of(input logic [1:0] size_bits);
    acc_size_e sz;
    case (size_bits)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] addr_lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Load result formatter: selects the byte/halfword lane addressed by addr
// and sign- or zero-extends it according to funct3.
// Ports: rdata (bus word), addr (byte offset in word), funct3 (size/sign),
//        result (formatted 32-bit load value).
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    result = rdata;

    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_BU:   result = {24'h000000, w_byte};
      F3_HU:   result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one bus access per load/store,
// stalls the pipeline until the bus answers (or times out), formats load
// data and flags misaligned accesses.
// Ports: clk/reset (sync, active-high); MemWriteM/MemReadM/Funct3M/
//        AluResultM/WriteDataM from EX/MEM; ReadDataM, StallM, MisalignM,
//        BusErrM to the pipeline; mem_req/mem_we/mem_addr/mem_wdata/mem_be
//        and mem_ready/mem_rdata on the bus side.
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  lsu_state_e        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_is_load;

  acc_size_e   w_size;
  logic        w_access;
  logic        w_misaligned;
  logic        w_timeout;
  bus_req_t    w_req;
  logic [31:0] w_fmt;

  // Decode the incoming request and build the lane-replicated bus payload.
  always_comb begin
    w_size       = size_of(Funct3M[1:0]);
    w_access     = MemWriteM | MemReadM;
    w_misaligned = is_misaligned(w_size, AluResultM[1:0]);
    w_req.we     = MemWriteM;
    w_req.addr   = {AluResultM[31:2], 2'b00};
    w_req.be     = 4'b0000;
    w_req.wdata  = 32'h0000_0000;
    if (MemWriteM) begin
      case (w_size)
        SZ_BYTE: begin
          w_req.be    = 4'b0001 << AluResultM[1:0];
          w_req.wdata = {4{WriteDataM[7:0]}};
        end
        SZ_HALF: begin
          w_req.be    = AluResultM[1] ? 4'b1100 : 4'b0011;
          w_req.wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          w_req.be    = 4'b1111;
          w_req.wdata = WriteDataM;
        end
      endcase
    end
  end

  // Stall starts in the issue cycle itself so the instruction stays in M.
  always_comb begin
    StallM    = 1'b0;
    MisalignM = 1'b0;
    if (!reset) begin
      StallM    = (r_state == ST_ACCESS) ||
                  ((r_state == ST_IDLE) && w_access && !w_misaligned);
      MisalignM = (r_state == ST_IDLE) && w_access && w_misaligned;
    end
  end

  assign w_timeout = (r_wait == WAIT_W'(MAX_WAIT - 1));

  load_formatter u_load_formatter (
    .rdata  (mem_rdata),
    .addr   (r_addr_lo),
    .funct3 (r_funct3),
    .result (w_fmt)
  );

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_is_load <= 1'b0;
      ReadDataM <= 32'h0000_0000;
      BusErrM   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
    end else begin
      BusErrM <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_misaligned) begin
            mem_req   <= 1'b1;
            mem_we    <= w_req.we;
            mem_addr  <= w_req.addr;
            mem_be    <= w_req.be;
            mem_wdata <= w_req.wdata;
            r_funct3  <= Funct3M;
            r_addr_lo <= AluResultM[1:0];
            r_is_load <= !MemWriteM;
            r_wait    <= '0;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_is_load) ReadDataM <= w_fmt;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            BusErrM <= 1'b1;
            if (r_is_load) ReadDataM <= 32'h0000_0000;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int unsigned MAX_WAIT = 16;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  Funct3M;
  logic [31:0] AluResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_hold = 32'h0;

  mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .Funct3M    (Funct3M),
    .AluResultM (AluResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    int bi;
    int hi;
    logic [7:0]  b;
    logic [15:0] h;
    bi = int'(a);
    hi = a[1] ? 1 : 0;
    b  = d[bi*8 +: 8];
    h  = d[hi*16 +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic clear_inputs();
    MemWriteM  = 1'b0;
    MemReadM   = 1'b0;
    Funct3M    = 3'b000;
    AluResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  // One aligned access; ready_at < 0 means the bus never answers.
  task automatic run_access(input string name, input logic we, input logic re,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ready_at, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    bit   exp_err;
    bit   is_load;
    bit   done;
    int   stall_cycles;
    int   exp_stall;
    logic [31:0] exp_rd;
    exp_err   = (ready_at < 0);
    is_load   = re && !we;
    exp_stall = exp_err ? int'(MAX_WAIT) + 1 : ready_at + 2;
    if (is_load) sb.push_back(exp_err ? 32'h0 : model_load(f3, addr[1:0], rdata));

    @(negedge clk);
    mem_ready  = 1'b0;
    MemWriteM  = we;
    MemReadM   = re;
    Funct3M    = f3;
    AluResultM = addr;
    WriteDataM = wdata;
    #1;
    chk({name, " idle_stall"}, 32'(StallM), 32'd1);
    chk({name, " idle_misalign"}, 32'(MisalignM), 32'd0);
    chk({name, " idle_buserr"}, 32'(BusErrM), 32'd0);
    stall_cycles = 1;

    @(negedge clk);
    chk({name, " req"}, 32'(mem_req), 32'd1);
    chk({name, " we"}, 32'(mem_we), 32'(we));
    chk({name, " addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({name, " be"}, 32'(mem_be), 32'(exp_be));
    if (we) chk({name, " wdata"}, mem_wdata, exp_wdata);

    done = 1'b0;
    for (int k = 0; k < int'(MAX_WAIT) + 2 && !done; k++) begin
      if (StallM) stall_cycles++;
      if (k == ready_at) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!StallM) done = 1'b1;
    end
    chk({name, " completed"}, 32'(done), 32'd1);

    chk({name, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    chk({name, " done_req"}, 32'(mem_req), 32'd0);
    chk({name, " done_buserr"}, 32'(BusErrM), 32'(exp_err));
    if (is_load) begin
      exp_rd = sb.pop_front();
      chk({name, " rdata"}, ReadDataM, exp_rd);
      exp_hold = exp_rd;
    end else begin
      chk({name, " rdata_hold"}, ReadDataM, exp_hold);
    end
    clear_inputs();
    // Stray response while in DONE must be ignored.
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic run_misalign(input string name, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    mem_ready  = 1'b0;
    MemReadM   = 1'b1;
    Funct3M    = f3;
    AluResultM = addr;
    #1;
    chk({name, " pulse"}, 32'(MisalignM), 32'd1);
    chk({name, " stall"}, 32'(StallM), 32'd0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk({name, " req"}, 32'(mem_req), 32'd0);
    chk({name, " pulse_end"}, 32'(MisalignM), 32'd0);
    chk({name, " rdata_hold"}, ReadDataM, exp_hold);
  endtask

  initial begin
    logic [2:0] codes [5];
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] d;
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst ReadDataM", ReadDataM, 32'h0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst StallM", 32'(StallM), 32'd0);
    chk("rst BusErrM", 32'(BusErrM), 32'd0);
    reset = 1'b0;

    run_access("lw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0);
    run_access("lb103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1, 4'b0000, 32'h0);
    run_access("lbu103", 1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 2, 4'b0000, 32'h0);
    run_access("sh202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD);
    run_access("sb201", 1'b1, 1'b0, 3'b000, 32'h201, 32'h12345678, 32'h0, 1, 4'b0010, 32'h78787878);
    run_access("sw204", 1'b1, 1'b0, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 3, 4'b1111, 32'hCAFEF00D);
    run_access("lh102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 4'b0000, 32'h0);
    run_access("lhu100", 1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 32'h8001F234, 0, 4'b0000, 32'h0);
    run_access("rsv011", 1'b0, 1'b1, 3'b011, 32'h108, 32'h0, 32'h11223344, 0, 4'b0000, 32'h0);
    run_access("both_sb", 1'b1, 1'b1, 3'b000, 32'h303, 32'h000000A5, 32'h0, 0, 4'b1000, 32'hA5A5A5A5);

    run_misalign("mis_lw101", 3'b010, 32'h101);
    run_misalign("mis_lhu103", 3'b101, 32'h103);

    for (int i = 0; i < 6; i++) begin
      f3 = codes[$urandom_range(0, 4)];
      a  = 32'h400 + 32'($urandom_range(0, 63));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      d  = $urandom;
      run_access("rnd_ld", 1'b0, 1'b1, f3, a, 32'h0, d, int'($urandom_range(0, 3)), 4'b0000, 32'h0);
    end

    run_access("lw_timeout", 1'b0, 1'b1, 3'b010, 32'h500, 32'h0, 32'h0, -1, 4'b0000, 32'h0);

    // Reset on the third ACCESS cycle of an unanswered load.
    run_access("lw_pre", 1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'h5555AAAA, 0, 4'b0000, 32'h0);
    @(negedge clk);
    mem_ready  = 1'b0;
    MemReadM   = 1'b1;
    Funct3M    = 3'b010;
    AluResultM = 32'h600;
    repeat (3) @(negedge clk);
    chk("rst_acc req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_acc req", 32'(mem_req), 32'd0);
    chk("rst_acc buserr", 32'(BusErrM), 32'd0);
    chk("rst_acc misalign", 32'(MisalignM), 32'd0);
    chk("rst_acc rdata", ReadDataM, 32'h0);
    clear_inputs();
    reset    = 1'b0;
    exp_hold = 32'h0;
    #1;
    chk("rst_acc idle_stall", 32'(StallM), 32'd0);
    run_access("lw_post", 1'b0, 1'b1, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 0, 4'b0000, 32'h0);

    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("end req", 32'(mem_req), 32'd0);
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
